// File: rtl/exec_mem_unit_pkg.sv
// Shared constants for the rv32i execute/memory slice: widths, ALU op codes,
// load/store func3 codes and byte-lane masks.
package exec_mem_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 12;
  localparam int DEPTH      = 2 ** (ADDR_WIDTH - 2);
  localparam int LANES      = DATA_WIDTH / 8;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;

  localparam logic [3:0] LANE_B0      = 4'b0001;
  localparam logic [3:0] LANE_B1      = 4'b0010;
  localparam logic [3:0] LANE_B2      = 4'b0100;
  localparam logic [3:0] LANE_B3      = 4'b1000;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_WORD    = 4'b1111;

endpackage

// File: rtl/exec_mem_unit_dmem_bram.sv
// Byte-enabled data RAM with an init/store write-source mux, combinational
// load read port and an always-on debug read port.
module exec_mem_unit_dmem_bram
  import exec_mem_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_mode,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_dat,
  input  logic                  init_enb,
  input  logic [LANES-1:0]      init_byte_enb,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_dat,
  input  logic                  mem_write,
  input  logic [LANES-1:0]      byte_enb,
  input  logic                  mem_read,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-3:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic                  wr_en;
  logic [LANES-1:0]      wr_lanes;
  logic                  unused_addr_bits;

  always_comb begin
    if (init_mode) begin
      wr_idx   = init_addr[ADDR_WIDTH-1:2];
      wr_dat   = init_dat;
      wr_en    = init_enb;
      wr_lanes = init_byte_enb;
    end else begin
      wr_idx   = addr[ADDR_WIDTH-1:2];
      wr_dat   = store_dat;
      wr_en    = mem_write;
      wr_lanes = byte_enb;
    end
  end

  // Contents survive reset; reset only blocks the write strobe.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int lane = 0; lane < LANES; lane++) begin
        if (wr_lanes[lane]) mem[wr_idx][8*lane +: 8] <= wr_dat[8*lane +: 8];
      end
    end
  end

  assign read_data  = mem_read ? mem[addr[ADDR_WIDTH-1:2]] : '0;
  assign debug_data = mem[debug_addr[ADDR_WIDTH-1:2]];

  assign unused_addr_bits = ^{init_addr[1:0], addr[1:0], debug_addr[1:0]};

endmodule

// File: rtl/exec_mem_unit.sv
// Execute + memory slice of the single-cycle rv32i core: ALU, data RAM and
// the load byte reader that feeds write-back.
module exec_mem_unit
  import exec_mem_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            alu_ctrl,
  input  logic                  alu_src,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [DATA_WIDTH-1:0] sign_ext,
  output logic [DATA_WIDTH-1:0] results,
  output logic                  zero,
  output logic                  res_last_bit,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [LANES-1:0]      byte_enb,
  input  logic [DATA_WIDTH-1:0] store_dat,
  input  logic [2:0]            func3,
  input  logic                  init_mode,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_dat,
  input  logic                  init_enb,
  input  logic [LANES-1:0]      init_byte_enb,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
);

  logic [DATA_WIDTH-1:0] op_b;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic                  byte_ok;
  logic                  half_ok;

  assign op_b  = alu_src ? sign_ext : src2;
  assign shamt = op_b[4:0];

  always_comb begin
    results = '0;
    case (alu_ctrl)
      ALU_ADD:  results = src1 + op_b;
      ALU_SUB:  results = src1 - op_b;
      ALU_AND:  results = src1 & op_b;
      ALU_OR:   results = src1 | op_b;
      ALU_XOR:  results = src1 ^ op_b;
      ALU_SLL:  results = src1 << shamt;
      ALU_SRL:  results = src1 >> shamt;
      ALU_SRA:  results = $signed(src1) >>> shamt;
      ALU_SLT:  results = {{(DATA_WIDTH-1){1'b0}}, ($signed(src1) < $signed(op_b))};
      ALU_SLTU: results = {{(DATA_WIDTH-1){1'b0}}, (src1 < op_b)};
      default:  results = '0;
    endcase
  end

  // Branch logic reads these: SUB+zero for BEQ/BNE, SLT(U)+bit 0 for BLT/BGE.
  assign zero         = (results == '0);
  assign res_last_bit = results[0];

  exec_mem_unit_dmem_bram u_dmem (
    .clk           (clk),
    .rst           (rst),
    .init_mode     (init_mode),
    .init_addr     (init_addr),
    .init_dat      (init_dat),
    .init_enb      (init_enb),
    .init_byte_enb (init_byte_enb),
    .addr          (results[ADDR_WIDTH-1:0]),
    .store_dat     (store_dat),
    .mem_write     (mem_write),
    .byte_enb      (byte_enb),
    .mem_read      (mem_read),
    .read_data     (rd_word),
    .debug_addr    (debug_addr),
    .debug_data    (debug_data)
  );

  always_comb begin
    sel_byte = rd_word[7:0];
    byte_ok  = 1'b1;
    case (byte_enb)
      LANE_B0: sel_byte = rd_word[7:0];
      LANE_B1: sel_byte = rd_word[15:8];
      LANE_B2: sel_byte = rd_word[23:16];
      LANE_B3: sel_byte = rd_word[31:24];
      default: byte_ok  = 1'b0;
    endcase
  end

  always_comb begin
    sel_half = rd_word[15:0];
    half_ok  = 1'b1;
    case (byte_enb)
      LANE_HALF_LO: sel_half = rd_word[15:0];
      LANE_HALF_HI: sel_half = rd_word[31:16];
      default:      half_ok  = 1'b0;
    endcase
  end

  // A lane mask that does not match the access width yields no write-back.
  always_comb begin
    wb_data  = '0;
    wb_valid = 1'b0;
    if (mem_read) begin
      case (func3)
        FUNC3_LB: if (byte_ok) begin
          wb_data  = {{24{sel_byte[7]}}, sel_byte};
          wb_valid = 1'b1;
        end
        FUNC3_LBU: if (byte_ok) begin
          wb_data  = {24'h0, sel_byte};
          wb_valid = 1'b1;
        end
        FUNC3_LH: if (half_ok) begin
          wb_data  = {{16{sel_half[15]}}, sel_half};
          wb_valid = 1'b1;
        end
        FUNC3_LHU: if (half_ok) begin
          wb_data  = {16'h0, sel_half};
          wb_valid = 1'b1;
        end
        FUNC3_LW: if (byte_enb == LANE_WORD) begin
          wb_data  = rd_word;
          wb_valid = 1'b1;
        end
        default: begin
          wb_data  = '0;
          wb_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed scoreboard bench for exec_mem_unit: stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_exec_mem_unit;

  localparam int SEL_RESULTS = 0;
  localparam int SEL_ZERO    = 1;
  localparam int SEL_LASTBIT = 2;
  localparam int SEL_WBDATA  = 3;
  localparam int SEL_WBVALID = 4;
  localparam int SEL_DEBUG   = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic [31:0] src1, src2, sign_ext;
  logic [31:0] results;
  logic        zero, res_last_bit;
  logic        mem_read, mem_write;
  logic [3:0]  byte_enb;
  logic [31:0] store_dat;
  logic [2:0]  func3;
  logic        init_mode;
  logic [11:0] init_addr;
  logic [31:0] init_dat;
  logic        init_enb;
  logic [3:0]  init_byte_enb;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [11:0] debug_addr;
  logic [31:0] debug_data;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          n_compared;
  int          n_mismatched;

  exec_mem_unit dut (
    .clk           (clk),
    .rst           (rst),
    .alu_ctrl      (alu_ctrl),
    .alu_src       (alu_src),
    .src1          (src1),
    .src2          (src2),
    .sign_ext      (sign_ext),
    .results       (results),
    .zero          (zero),
    .res_last_bit  (res_last_bit),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .byte_enb      (byte_enb),
    .store_dat     (store_dat),
    .func3         (func3),
    .init_mode     (init_mode),
    .init_addr     (init_addr),
    .init_dat      (init_dat),
    .init_enb      (init_enb),
    .init_byte_enb (init_byte_enb),
    .wb_data       (wb_data),
    .wb_valid      (wb_valid),
    .debug_addr    (debug_addr),
    .debug_data    (debug_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: the outputs are combinational, so every queued expectation is
  // checked at the negedge following its stimulus.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        case (mon_e.sel)
          SEL_RESULTS: mon_act = results;
          SEL_ZERO:    mon_act = {31'b0, zero};
          SEL_LASTBIT: mon_act = {31'b0, res_last_bit};
          SEL_WBDATA:  mon_act = wb_data;
          SEL_WBVALID: mon_act = {31'b0, wb_valid};
          default:     mon_act = debug_data;
        endcase
        n_compared++;
        if (mon_act !== mon_e.exp) begin
          n_mismatched++;
          $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  // Start a new cycle of stimulus; one-shot strobes default low.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    init_enb  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic setAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_imm, input logic [31:0] imm);
    alu_ctrl = op;
    src1     = a;
    src2     = b;
    alu_src  = use_imm;
    sign_ext = imm;
  endtask

  task automatic initWrite(input logic [11:0] a, input logic [31:0] d);
    applyStimulus();
    init_mode     = 1'b1;
    init_enb      = 1'b1;
    init_byte_enb = 4'b1111;
    init_addr     = a;
    init_dat      = d;
  endtask

  task automatic loadCheck(input string name, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [3:0] lanes, input logic rd,
                           input logic [31:0] exp_data, input logic exp_valid);
    applyStimulus();
    setAlu(4'b0000, addr, 32'h0, 1'b1, 32'h0);
    mem_read = rd;
    func3    = f3;
    byte_enb = lanes;
    checkOutput({name, "_data"}, SEL_WBDATA, exp_data);
    checkOutput({name, "_valid"}, SEL_WBVALID, {31'b0, exp_valid});
  endtask

  initial begin
    rst = 1'b0;
    alu_ctrl = 4'h0; alu_src = 1'b0; src1 = '0; src2 = '0; sign_ext = '0;
    mem_read = 1'b0; mem_write = 1'b0; byte_enb = 4'h0; store_dat = '0; func3 = 3'h0;
    init_mode = 1'b0; init_addr = '0; init_dat = '0; init_enb = 1'b0; init_byte_enb = 4'h0;
    debug_addr = '0;

    applyStimulus();
    checkOutput("reset_results", SEL_RESULTS, 32'h0);
    checkOutput("reset_zero", SEL_ZERO, 32'h1);
    checkOutput("reset_wb_valid", SEL_WBVALID, 32'h0);
    checkOutput("reset_wb_data", SEL_WBDATA, 32'h0);

    applyStimulus();
    rst = 1'b1;
    setAlu(4'b0001, 32'd3, 32'd3, 1'b0, 32'h0);
    checkOutput("beq_eq_results", SEL_RESULTS, 32'h0);
    checkOutput("beq_eq_zero", SEL_ZERO, 32'h1);

    applyStimulus();
    setAlu(4'b0001, 32'd3, 32'd5, 1'b0, 32'h0);
    checkOutput("beq_ne_results", SEL_RESULTS, 32'hFFFF_FFFE);
    checkOutput("beq_ne_zero", SEL_ZERO, 32'h0);

    applyStimulus();
    setAlu(4'b0001, 32'h8000_0000, 32'h0, 1'b1, 32'd1);
    checkOutput("sub_wrap", SEL_RESULTS, 32'h7FFF_FFFF);

    applyStimulus();
    setAlu(4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    checkOutput("slt_lastbit", SEL_LASTBIT, 32'h1);
    checkOutput("slt_results", SEL_RESULTS, 32'h1);

    applyStimulus();
    setAlu(4'b1001, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    checkOutput("sltu_lastbit", SEL_LASTBIT, 32'h0);

    applyStimulus();
    setAlu(4'b0111, 32'h8000_0000, 32'h0, 1'b1, 32'd4);
    checkOutput("sra", SEL_RESULTS, 32'hF800_0000);

    applyStimulus();
    setAlu(4'b0110, 32'h8000_0000, 32'd4, 1'b0, 32'h0);
    checkOutput("srl", SEL_RESULTS, 32'h0800_0000);

    applyStimulus();
    setAlu(4'b0101, 32'h1, 32'h21, 1'b0, 32'h0);
    checkOutput("sll_shamt_mask", SEL_RESULTS, 32'h2);

    applyStimulus();
    setAlu(4'b0010, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'h0);
    checkOutput("and", SEL_RESULTS, 32'h00F0_0034);

    applyStimulus();
    setAlu(4'b0011, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'h0);
    checkOutput("or", SEL_RESULTS, 32'hFFF0_12FF);

    applyStimulus();
    setAlu(4'b0100, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'h0);
    checkOutput("xor", SEL_RESULTS, 32'hFF00_12CB);

    applyStimulus();
    setAlu(4'b1111, 32'h1234_5678, 32'h1, 1'b0, 32'h0);
    checkOutput("bad_op", SEL_RESULTS, 32'h0);

    initWrite(12'h000, 32'h0000_0003);
    initWrite(12'h004, 32'h0000_0003);
    initWrite(12'h008, 32'h0000_0005);
    initWrite(12'h010, 32'h80FF_7F01);

    applyStimulus();
    init_mode  = 1'b0;
    debug_addr = 12'h008;
    checkOutput("init_word8", SEL_DEBUG, 32'h0000_0005);

    applyStimulus();
    setAlu(4'b0000, 32'd8, 32'h0, 1'b1, 32'd4);
    mem_write = 1'b1;
    store_dat = 32'h0000_0005;
    byte_enb  = 4'b1111;
    checkOutput("store_addr", SEL_RESULTS, 32'h0000_000C);

    applyStimulus();
    debug_addr = 12'h00C;
    checkOutput("store_word", SEL_DEBUG, 32'h0000_0005);

    loadCheck("lb_lane1",  32'h11,   3'b000, 4'b0010, 1'b1, 32'h0000_007F, 1'b1);
    loadCheck("lb_lane2",  32'h11,   3'b000, 4'b0100, 1'b1, 32'hFFFF_FFFF, 1'b1);
    loadCheck("lbu_lane2", 32'h11,   3'b100, 4'b0100, 1'b1, 32'h0000_00FF, 1'b1);
    loadCheck("lh_high",   32'h11,   3'b001, 4'b1100, 1'b1, 32'hFFFF_80FF, 1'b1);
    loadCheck("lhu_low",   32'h11,   3'b101, 4'b0011, 1'b1, 32'h0000_7F01, 1'b1);
    loadCheck("lw_badlane", 32'h11,  3'b010, 4'b0011, 1'b1, 32'h0,         1'b0);
    loadCheck("lb_twohot", 32'h11,   3'b000, 4'b0011, 1'b1, 32'h0,         1'b0);
    loadCheck("lw_wrap",   32'h1010, 3'b010, 4'b1111, 1'b1, 32'h80FF_7F01, 1'b1);
    loadCheck("lw_noread", 32'h10,   3'b010, 4'b1111, 1'b0, 32'h0,         1'b0);

    applyStimulus();
    setAlu(4'b0000, 32'd4, 32'h0, 1'b1, 32'h0);
    mem_write = 1'b1;
    mem_read  = 1'b1;
    func3     = 3'b000;
    byte_enb  = 4'b0010;
    store_dat = 32'h0000_AA00;
    checkOutput("rdw_old_data", SEL_WBDATA, 32'h0);

    applyStimulus();
    mem_read   = 1'b1;
    debug_addr = 12'h004;
    checkOutput("lane_store_lb", SEL_WBDATA, 32'hFFFF_FFAA);
    checkOutput("lane_store_word", SEL_DEBUG, 32'h0000_AA03);

    applyStimulus();
    rst = 1'b0;
    setAlu(4'b0000, 32'h0, 32'h0, 1'b1, 32'h0);
    mem_write  = 1'b1;
    store_dat  = 32'hDEAD_BEEF;
    byte_enb   = 4'b1111;
    debug_addr = 12'h000;
    checkOutput("rst_pre_write", SEL_DEBUG, 32'h0000_0003);

    applyStimulus();
    rst       = 1'b1;
    mem_write = 1'b1;
    checkOutput("rst_write_blocked", SEL_DEBUG, 32'h0000_0003);

    applyStimulus();
    checkOutput("post_rst_write", SEL_DEBUG, 32'hDEAD_BEEF);

    @(negedge clk);
    #1;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0 pending", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
